// File: rtl/approx_mult_erc_seq.sv
// rtl/approx_mult_erc_seq.sv - sequential OR-approximate multiplier with top-bit error recovery
// Optional feature macro: ERR_STATS_EN adds a saturating inexact-result counter err_count.
module approx_mult_erc_seq #(
  parameter int WIDTH        = 8,
  parameter int RECOVER_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   approx,
  output logic [2*WIDTH-1:0]   err_vec
`ifdef ERR_STATS_EN
  ,
  output logic [15:0]          err_count
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] ONES     = '1;
  localparam logic [PW-1:0] MASK     = ~(ONES >> RECOVER_BITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, RECOVER, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]   acc_q, err_q;
  logic [IW-1:0]   idx_q;
  logic [PW-1:0]   product_q, approx_q, err_vec_q;
  logic [PW-1:0]   a_ext, pp;

  assign a_ext = {{WIDTH{1'b0}}, a_q};
  assign pp    = b_q[idx_q] ? (a_ext << idx_q) : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ACCUM;
      ACCUM:   if (idx_q == IDX_LAST) state_d = RECOVER;
      RECOVER: state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // acc keeps the carry-free OR sum; the AND term is exactly what the OR dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      err_q     <= '0;
      idx_q     <= '0;
      product_q <= '0;
      approx_q  <= '0;
      err_vec_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          acc_q <= '0;
          err_q <= '0;
          idx_q <= '0;
        end
        ACCUM: begin
          acc_q <= acc_q | pp;
          err_q <= err_q + (acc_q & pp);
          idx_q <= idx_q + 1'b1;
        end
        RECOVER: begin
          product_q <= acc_q + (err_q & MASK);
          approx_q  <= acc_q;
          err_vec_q <= err_q;
        end
        default: ;
      endcase
    end
  end

`ifdef ERR_STATS_EN
  logic [15:0] err_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (state_q == RECOVER && |(err_q & ~MASK) && err_count_q != 16'hFFFF) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end
  assign err_count = err_count_q;
`endif

  assign product = product_q;
  assign approx  = approx_q;
  assign err_vec = err_vec_q;

endmodule

// File: tb/tb_approx_mult_erc_seq.sv
// tb/tb_approx_mult_erc_seq.sv - scoreboard bench for approx_mult_erc_seq at RECOVER_BITS 8, 16 and 0
module tb_approx_mult_erc_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [7:0]  a, b;
  logic        rdy8, rdy16, rdy0, ov8, ov16, ov0;
  logic [15:0] prod8, apx8, ev8, prod16, apx16, ev16, prod0, apx0, ev0;
`ifdef ERR_STATS_EN
  logic [15:0] cnt8, cnt16, cnt0;
  int          exp_cnt = 0;
`endif

  typedef struct packed {
    logic [15:0] acc;
    logic [15:0] err;
    logic [15:0] p8;
    logic [15:0] p16;
    logic [15:0] p0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  approx_mult_erc_seq #(.WIDTH(8), .RECOVER_BITS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .a(a), .b(b),
    .out_valid(ov8), .out_ready(out_ready), .product(prod8), .approx(apx8), .err_vec(ev8)
`ifdef ERR_STATS_EN
    , .err_count(cnt8)
`endif
  );
  approx_mult_erc_seq #(.WIDTH(8), .RECOVER_BITS(16)) dut_exact (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .a(a), .b(b),
    .out_valid(ov16), .out_ready(out_ready), .product(prod16), .approx(apx16), .err_vec(ev16)
`ifdef ERR_STATS_EN
    , .err_count(cnt16)
`endif
  );
  approx_mult_erc_seq #(.WIDTH(8), .RECOVER_BITS(0)) dut_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready), .product(prod0), .approx(apx0), .err_vec(ev0)
`ifdef ERR_STATS_EN
    , .err_count(cnt0)
`endif
  );

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [15:0] pp;
    e.acc = '0;
    e.err = '0;
    for (int i = 0; i < 8; i++) begin
      pp    = y[i] ? ({8'h00, x} << i) : 16'h0000;
      e.err = e.err + (e.acc & pp);
      e.acc = e.acc | pp;
    end
    e.p8  = e.acc + (e.err & 16'hFF00);
    e.p16 = e.acc + e.err;
    e.p0  = e.acc;
    return e;
  endfunction

  task automatic push_exp(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e = model(x, y);
    sb.push_back(e);
`ifdef ERR_STATS_EN
    if ((e.err & 16'h00FF) != 16'h0000 && exp_cnt < 65535) exp_cnt++;
`endif
  endtask

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input int hold, input bit scramble,
                        output logic [15:0] p_o, output logic [15:0] apx_o, output logic [15:0] ev_o);
    exp_t e;
    int   lat;
    bit   got;
    p_o = '0; apx_o = '0; ev_o = '0;
    @(negedge clk);
    checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL in_ready_idle: got %b want 1", rdy8); end
    in_valid = 1'b1; a = x; b = y;
    push_exp(x, y);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (ov8 === 1'b1) got = 1'b1;
      else begin
        if (scramble) begin in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom); end
        @(negedge clk);
        lat++;
      end
    end
    in_valid = 1'b0;
    checks++; if (!got) begin errors++; $display("FAIL timeout_out_valid: got 0 want 1"); void'(sb.pop_front()); return; end
    checks++; if (lat != 9) begin errors++; $display("FAIL latency: got %0d want 9", lat); end
    checks++; if ({ov16, ov0} !== 2'b11) begin errors++; $display("FAIL out_valid_variants: got %b want 11", {ov16, ov0}); end
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++; if ({ov8, rdy8} !== 2'b10) begin errors++; $display("FAIL hold_flags: got %b want 10", {ov8, rdy8}); end
      checks++; if (prod8 !== e.p8 || apx8 !== e.acc || ev8 !== e.err) begin
        errors++; $display("FAIL hold_stable: got %h/%h/%h want %h/%h/%h", prod8, apx8, ev8, e.p8, e.acc, e.err); end
    end
    checks++; if (apx8 !== e.acc) begin errors++; $display("FAIL approx: got %h want %h", apx8, e.acc); end
    checks++; if (ev8 !== e.err) begin errors++; $display("FAIL err_vec: got %h want %h", ev8, e.err); end
    checks++; if (prod8 !== e.p8) begin errors++; $display("FAIL product_rb8: got %h want %h", prod8, e.p8); end
    checks++; if (prod16 !== e.p16) begin errors++; $display("FAIL product_rb16: got %h want %h", prod16, e.p16); end
    checks++; if (prod0 !== e.p0) begin errors++; $display("FAIL product_rb0: got %h want %h", prod0, e.p0); end
    checks++; if (prod16 !== 16'(x * y)) begin errors++; $display("FAIL exact_vs_mul: got %h want %h", prod16, 16'(x * y)); end
    p_o = prod8; apx_o = apx8; ev_o = ev8;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if ({ov8, rdy8} !== 2'b01) begin errors++; $display("FAIL after_handshake: got %b want 01", {ov8, rdy8}); end
    checks++; if (prod8 !== e.p8) begin errors++; $display("FAIL retain_product: got %h want %h", prod8, e.p8); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if ({rdy8, ov8} !== 2'b10) begin errors++; $display("FAIL reset_flags: got %b want 10", {rdy8, ov8}); end
    checks++; if ({prod8, apx8, ev8} !== 48'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {prod8, apx8, ev8}); end
  endtask

  task automatic test_known();
    logic [15:0] p, x, e;
    run_op(8'hFF, 8'hFF, 0, 1'b0, p, x, e);
    checks++; if ({p, x, e} !== {16'hFDFF, 16'h7FFF, 16'h7E02}) begin
      errors++; $display("FAIL ff_ff: got %h/%h/%h want fdff/7fff/7e02", p, x, e); end
    checks++; if ({prod16, prod0} !== {16'hFE01, 16'h7FFF}) begin
      errors++; $display("FAIL ff_ff_variants: got %h/%h want fe01/7fff", prod16, prod0); end
    run_op(8'h0F, 8'h03, 0, 1'b0, p, x, e);
    checks++; if ({p, x, e} !== {16'h001F, 16'h001F, 16'h000E}) begin
      errors++; $display("FAIL 0f_03: got %h/%h/%h want 001f/001f/000e", p, x, e); end
    run_op(8'h03, 8'h05, 0, 1'b0, p, x, e);
    checks++; if ({p, e} !== {16'h000F, 16'h0000}) begin
      errors++; $display("FAIL 03_05: got %h/%h want 000f/0000", p, e); end
    run_op(8'h00, 8'hAB, 0, 1'b0, p, x, e);
    checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_operand: got %h want 0000", p); end
  endtask

  task automatic test_hold_and_scramble();
    logic [15:0] p, x, e;
    run_op(8'hA5, 8'h3C, 5, 1'b0, p, x, e);
    run_op(8'hC3, 8'h7E, 2, 1'b1, p, x, e);
    run_op(8'h80, 8'hFF, 0, 1'b1, p, x, e);
  endtask

  task automatic test_mid_reset();
    logic [15:0] p, x, e;
    @(negedge clk);
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef ERR_STATS_EN
    exp_cnt = 0;
`endif
    checks++; if ({rdy8, ov8, rdy16, ov16} !== 4'b1010) begin
      errors++; $display("FAIL midreset_flags: got %b want 1010", {rdy8, ov8, rdy16, ov16}); end
    checks++; if ({prod8, apx8, ev8, prod16} !== 64'h0) begin
      errors++; $display("FAIL midreset_outputs: got %h want 0", {prod8, apx8, ev8, prod16}); end
    run_op(8'h96, 8'h69, 0, 1'b0, p, x, e);
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs[3] = '{8'h5A, 8'hFF, 8'h12};
    logic [7:0] ys[3] = '{8'hC7, 8'h81, 8'h34};
    int   nxt = 0, done = 0, cyc = 0, last_acc = -1;
    exp_t e;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && done < 3; k++) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      if (ov8 === 1'b1) begin
        e = sb.pop_front();
        checks++; if (prod8 !== e.p8 || apx8 !== e.acc || ev8 !== e.err || prod16 !== e.p16) begin
          errors++; $display("FAIL b2b_result: got %h/%h/%h/%h want %h/%h/%h/%h",
                             prod8, apx8, ev8, prod16, e.p8, e.acc, e.err, e.p16); end
        done++;
      end
      if (rdy8 === 1'b1 && nxt < 3) begin
        in_valid = 1'b1; a = xs[nxt]; b = ys[nxt];
        push_exp(xs[nxt], ys[nxt]);
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc != 11) begin errors++; $display("FAIL b2b_interval: got %0d want 11", cyc - last_acc); end
        end
        last_acc = cyc;
        nxt++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (done != 3) begin errors++; $display("FAIL b2b_timeout: got %0d want 3", done); end
    @(negedge clk);
  endtask

`ifdef ERR_STATS_EN
  task automatic test_err_stats();
    checks++; if (cnt8 !== 16'(exp_cnt)) begin errors++; $display("FAIL err_count_rb8: got %0d want %0d", cnt8, exp_cnt); end
    checks++; if (cnt16 !== 16'h0) begin errors++; $display("FAIL err_count_rb16: got %0d want 0", cnt16); end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known();
    test_hold_and_scramble();
    test_mid_reset();
    test_back_to_back();
`ifdef ERR_STATS_EN
    test_err_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_mult_erc_seq.md
Name: approx_mult_erc_seq

Overview:
- Sequential, parametrised approximate multiplier with error recovery.
- Partial products are folded one per cycle using an approximate OR-adder. The exact residual (the AND term) is accumulated into an error vector.
- The top RECOVER_BITS of the error vector are added back at the end.
- Successor to the fixed-width combinational reduction layers: configurable width and recovery depth, with valid/ready handshaking for integration in the datapath.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH bits.
- RECOVER_BITS, 8, number of MSBs of the 2*WIDTH error vector added back. Legal range 0..2*WIDTH: 0 gives pure approximate output, 2*WIDTH gives the exact product.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand (unsigned)
- b  in  WIDTH  multiplier (unsigned)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- product  out  2*WIDTH  recovered product
- approx  out  2*WIDTH  uncorrected OR-accumulated result
- err_vec  out  2*WIDTH  full accumulated error vector

Behaviour:
- States: IDLE, ACCUM, RECOVER, DONE.
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - in_ready=1, out_valid=0.
  - product, approx and err_vec = 0.
  - Internal acc, err and bit counter = 0.
  - Reset mid-operation discards the operation in flight; no output is produced for it.
- in_ready=1 only in IDLE.
- IDLE:
  - On in_valid&&in_ready: capture a and b into registers; clear acc, err and idx; go to ACCUM.
  - Later changes on a and b are ignored.
- ACCUM, exactly WIDTH cycles, idx=0..WIDTH-1:
  - pp = b_r[idx] ? (a_r<<idx) : 0, zero-extended to 2*WIDTH.
  - acc <= acc | pp.
  - err <= err + (acc & pp), 2*WIDTH bits.
  - After idx=WIDTH-1, go to RECOVER.
- Identity: acc + err equals the exact product, so err never overflows 2*WIDTH.
- RECOVER, 1 cycle:
  - mask = top RECOVER_BITS bits set, i.e. bits [2W-1 : 2W-RECOVER_BITS]; mask=0 when RECOVER_BITS=0.
  - product <= acc + (err & mask), which cannot overflow.
  - approx <= acc; err_vec <= err.
  - out_valid <= 1; go to DONE.
- Latency: out_valid rises WIDTH+1 cycles after the accept edge (9 for WIDTH=8).
- DONE:
  - Outputs are held stable while out_valid=1 && out_ready=0.
  - On out_ready=1: out_valid <= 0 and go to IDLE. in_ready is 1 on the following cycle.
  - No overlap between operations.
  - Outputs retain their last values after the handshake until the next RECOVER.
- Throughput: one result per WIDTH+3 cycles when the consumer is always ready.
- Zero operands take the same path and latency.
- Throughout: in_valid while busy is ignored (in_ready=0); out_ready outside DONE is ignored.

Optional Feature:
- Macro: ERR_STATS_EN.
- Defined:
  - Adds output err_count (16 bits), reset to 0.
  - Incremented at each RECOVER where (err & ~mask) != 0, i.e. the emitted product is inexact.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, RECOVER_BITS=8, a=8'hFF, b=8'hFF -> approx=16'h7FFF, err_vec=16'h7E02, product=16'hFDFF, out_valid on 9th cycle after accept.
- Same operands with RECOVER_BITS=16 -> product=16'hFE01 (exact). With RECOVER_BITS=0 -> product=16'h7FFF.
- a=8'h0F, b=8'h03, RECOVER_BITS=8 -> approx=16'h001F, err_vec=16'h000E, product=16'h001F. a=3, b=5 -> err_vec=0, product=16'h000F.
- Handshake: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Toggle a, b and in_valid during ACCUM -> result unaffected. Assert out_ready -> in_ready=1 next cycle.
- Assert rst during ACCUM idx=4 -> next cycle IDLE, out_valid=0, outputs 0. A new operation then completes correctly.
- ERR_STATS_EN: 3 ops (FFxFF, 3x5, 0Fx03) at RECOVER_BITS=8 -> err_count=2. Force counter to 16'hFFFF and run another inexact op -> stays 16'hFFFF.
